alu: RTL and testbench

Synchronous integer ALU for the RISC datapath. It performs add, subtract, add-with-carry and subtract-with-borrow on two operand words and returns a registered result word. The result word carries the DATA_WIDTH-bit result plus a carry/borrow flag and an exception flag. It sits between the register-file read ports and the write-back stage, and holds an internal carry flag used to chain multi-word arithmetic.

---
 rtl/alu.sv | 78 +++++++
 tb/tb_alu.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered integer ALU: add/sub with optional carry/borrow chaining through an
// internal carry register; result word packs {X, C, data}.
module alu #(
  parameter int NB_REGISTERS = 34,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [2:0]              i_alu_ctrl,
  input  logic [NB_REGISTERS-1:0] i_data_A,
  input  logic [NB_REGISTERS-1:0] i_data_B,
  output logic [NB_REGISTERS-1:0] o_data
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_ADDC = 3'd2;
  localparam logic [2:0] OP_SUBC = 3'd3;

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] res;
  logic [DATA_WIDTH:0]   wide;
  logic                  cin;
  logic                  c_next;
  logic                  x_next;
  logic                  arith;
  logic                  carry_q;

  // The two upper operand bits are architecturally ignored.
  logic unused_upper;
  assign unused_upper = &{1'b0, i_data_A[NB_REGISTERS-1:DATA_WIDTH],
                          i_data_B[NB_REGISTERS-1:DATA_WIDTH]};

  always_comb begin
    a      = i_data_A[DATA_WIDTH-1:0];
    b      = i_data_B[DATA_WIDTH-1:0];
    cin    = i_alu_ctrl[1] & carry_q;
    wide   = '0;
    res    = '0;
    c_next = 1'b0;
    x_next = 1'b0;
    arith  = 1'b0;
    case (i_alu_ctrl)
      OP_ADD, OP_ADDC: begin
        wide   = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};
        res    = wide[DATA_WIDTH-1:0];
        c_next = wide[DATA_WIDTH];
        x_next = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
        arith  = 1'b1;
      end
      OP_SUB, OP_SUBC: begin
        // A negative (DATA_WIDTH+1)-bit difference sets the top bit: that is the borrow.
        wide   = {1'b0, a} - {1'b0, b} - {{DATA_WIDTH{1'b0}}, cin};
        res    = wide[DATA_WIDTH-1:0];
        c_next = wide[DATA_WIDTH];
        x_next = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
        arith  = 1'b1;
      end
      default: begin
        x_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data  <= '0;
      carry_q <= 1'b0;
    end else begin
      o_data <= {x_next, c_next, res};
      if (arith) carry_q <= c_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboarded bench for alu: stimulus pushes expected words from a signed/unsigned
// arithmetic model; an independent monitor pops and compares one cycle later.
module tb_alu;

  localparam int NB = 34;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [2:0]    ctrl;
  logic [NB-1:0] data_a;
  logic [NB-1:0] data_b;
  logic [NB-1:0] data_o;

  typedef struct {
    logic [NB-1:0] exp;
    string         name;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  model_carry = 1'b0;

  alu #(.NB_REGISTERS(NB), .DATA_WIDTH(DW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_alu_ctrl (ctrl),
    .i_data_A   (data_a),
    .i_data_B   (data_b),
    .o_data     (data_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer math, overflow judged against the true signed range.
  function automatic logic [NB-1:0] model(input bit r, input logic [2:0] op,
                                          input logic [NB-1:0] av, input logic [NB-1:0] bv);
    longint ua, ub, us, sa, sb, ss, ci;
    logic [DW-1:0] d;
    bit c, x;
    if (r) begin
      model_carry = 1'b0;
      return '0;
    end
    if (op > 3) return {1'b1, 1'b0, {DW{1'b0}}};
    ua = longint'(av[DW-1:0]);
    ub = longint'(bv[DW-1:0]);
    sa = (ua >= 64'sd2147483648) ? ua - 64'sd4294967296 : ua;
    sb = (ub >= 64'sd2147483648) ? ub - 64'sd4294967296 : ub;
    ci = (op >= 2 && model_carry) ? 1 : 0;
    if (op == 0 || op == 2) begin
      us = ua + ub + ci;
      ss = sa + sb + ci;
      c  = (us >= 64'sd4294967296);
    end else begin
      us = ua - ub - ci;
      ss = sa - sb - ci;
      c  = (ua < ub + ci);
    end
    if (us < 0) us = us + 64'sd4294967296;
    d = us[DW-1:0];
    x = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    model_carry = c;
    return {x, c, d};
  endfunction

  task automatic issue(input bit r, input logic [2:0] op, input logic [NB-1:0] av,
                       input logic [NB-1:0] bv, input string nm);
    sb_t e;
    @(negedge clk);
    rst    = r;
    ctrl   = op;
    data_a = av;
    data_b = bv;
    e.exp  = model(r, op, av, bv);
    e.name = nm;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (data_o !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, data_o, e.exp);
        end
      end
    end
  end

  initial begin : stim
    logic [NB-1:0] ra, rb;
    logic [2:0]    rop;
    int            wait_cnt;
    rst = 1'b1; ctrl = '0; data_a = '0; data_b = '0;

    issue(1, 3'd0, 34'h3_FFFF_FFFF, 34'h1, "reset");
    issue(0, 3'd4, 34'h0, 34'h0, "exception");
    issue(0, 3'd2, 34'h0, 34'h0, "addc_after_reset_cin0");
    issue(0, 3'd0, 34'h0_FFFF_FFFB, 34'h1, "add_neg5_plus1");
    issue(0, 3'd0, 34'h0_FFFF_FFFF, 34'h1, "add_carry_out");
    issue(0, 3'd2, 34'h0, 34'h0, "addc_chain");
    issue(0, 3'd1, 34'h0_8000_0000, 34'h1, "sub_overflow");
    issue(0, 3'd1, 34'h1, 34'h2, "sub_borrow");
    issue(0, 3'd3, 34'h5, 34'h1, "subc_chain");
    issue(0, 3'd0, 34'h0_7FFF_FFFF, 34'h1, "add_overflow");
    issue(0, 3'd0, 34'h0_FFFF_FFFF, 34'h0_FFFF_FFFF, "add_c1");
    issue(0, 3'd5, 34'h3_1234_5678, 34'h1, "reserved5_keeps_carry");
    issue(0, 3'd7, 34'h0, 34'h0, "reserved7");
    issue(0, 3'd2, 34'h0, 34'h0, "addc_after_reserved");
    issue(0, 3'd0, 34'h0_FFFF_FFFF, 34'h1, "add_pre_reset");
    issue(1, 3'd2, 34'h0_FFFF_FFFF, 34'h1, "reset_mid_chain");
    issue(0, 3'd2, 34'h0, 34'h0, "addc_after_mid_reset");
    issue(0, 3'd3, 34'h3_0000_0000, 34'h2_0000_0000, "subc_upper_bits_ignored");
    issue(0, 3'd1, 34'h0, 34'h0_FFFF_FFFF, "sub_0_minus_max");

    for (int i = 0; i < 3000; i++) begin
      ra  = {$urandom_range(3, 0), $urandom()};
      rb  = {$urandom_range(3, 0), $urandom()};
      rop = 3'($urandom_range(7, 0));
      if ($urandom_range(3, 0) == 0) rb = ra;
      if ($urandom_range(7, 0) == 0) ra[DW-1:0] = {DW{1'b1}};
      issue($urandom_range(49, 0) == 0, rop, ra, rb, "random");
    end

    @(negedge clk);
    rst = 1'b0; ctrl = 3'd4;
    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
